result_nibble_tx: RTL
=====================

Name: result_nibble_tx

Overview:
Transmit end of the registered byte-result path. Accepts 8-bit result words with carry/overflow status through a valid/ready handshake. Buffers them in a small FIFO and serializes each word onto a 4-bit nibble stream, low nibble first. Status flags are attached to the last beat of each word. Sits between the byte-wide AND/register stage and a narrow downstream link.

Parameters:
DATA_W, 8, input word width; must be an integer multiple of NIB_W.
NIB_W, 4, output beat width.
DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  FIFO can accept a word
in_data  input  DATA_W  result word
in_carry  input  1  carry status for in_data
in_overflow  input  1  overflow status for in_data
out_valid  output  1  out_nibble valid
out_ready  input  1  downstream accepts beat
out_nibble  output  NIB_W  current beat
out_first  output  1  beat is first of word
out_last  output  1  beat is last of word
out_flags  output  2  {carry, overflow}; valid only when out_last=1, otherwise 0

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - FIFO empty; beat counter 0.
  - in_ready=1; out_valid=0, out_nibble=0, out_first=0, out_last=0, out_flags=0.
- Push: in_valid && in_ready at a clk edge stores {in_data, in_carry, in_overflow} at the write pointer.
- in_ready = !full. A push is refused when the FIFO is full, even if a pop occurs in the same cycle; no bypass.
- Output is driven from the FIFO head entry and registered state only. out_valid = !empty.
- Latency: a word pushed into an empty FIFO at edge N appears on out_valid in the cycle after edge N.
- Beat counter b runs 0..BEATS-1, where BEATS = DATA_W/NIB_W.
  - out_nibble = head.data[b*NIB_W +: NIB_W].
  - out_first = (b==0). out_last = (b==BEATS-1).
- Beat transfer: out_valid && out_ready at an edge.
  - Non-last beat: b increments.
  - Last beat: b returns to 0 and the head is popped.
- Stall: while out_valid=1 and out_ready=0, all out_* outputs hold stable. The head is never altered by pushes.
- Simultaneous push and pop when not full: both occur; occupancy is unchanged.
- Throughput: with out_ready held at 1, one beat per cycle and no bubble between words.
- Pointer wrap: log2(DEPTH)+1-bit pointers. full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Reset mid-word: any partial word and all buffered words are discarded. The outputs return to their reset values immediately on assertion.
- out_valid never depends combinationally on out_ready.

Optional Feature:
PARITY_NIBBLE_EN
- Defined:
  - One extra beat is appended per word (BEATS+1 beats total).
  - Extra beat value = XOR of all data nibbles of the word.
  - out_last and out_flags move to the extra beat; the last data beat has out_last=0.
- Undefined: BEATS beats per word exactly as described above.

Test Plan:
- Single word: in_data=0xA5, carry=1, overflow=0, out_ready=1.
  - Expect beat 0x5 with first=1, last=0, then beat 0xA with first=0, last=1, flags=2'b10.
  - out_valid=0 afterwards.
- Backpressure: during beat 0x5 of 0x3C, out_ready=0 for 3 cycles.
  - out_nibble=0xC, first=1 and out_valid=1 held stable for all 3 cycles.
  - 0x3 follows once out_ready=1.
- Full: out_ready=0, push 0x11 then 0x22.
  - in_ready=0 after the second push; a held third word 0x33 is not accepted.
  - Release out_ready: beats 1,1,2,2,3,3; in_ready returns to 1 after 0x11 pops.
- Streaming: out_ready=1, in_valid=1 with words 0x01, 0x23, 0x45, 0x67.
  - 8 consecutive beats 1,0,3,2,5,4,7,6 with no idle cycle.
- Reset mid-word: push 0xF0, accept beat 0x0, then pulse rst_n low between edges.
  - out_valid=0 and in_ready=1 immediately; beat 0xF never appears.
- With PARITY_NIBBLE_EN: word 0xA5, overflow=1.
  - Beats 0x5, 0xA, 0xF; last=1 and flags=2'b01 on 0xF only.

Source files
------------

// File: rtl/result_nibble_tx.sv
// result_nibble_tx
//   Transmit end of the byte-result path. Words of DATA_W bits plus
//   carry/overflow status are accepted over a valid/ready handshake and
//   held in a DEPTH-entry FIFO. Each word is then sent as NIB_W-bit beats,
//   lowest nibble first. The status flags ride on the last beat of the word.
//
//   Optional build macro: PARITY_NIBBLE_EN
//     When defined, one extra beat is appended to every word. It carries the
//     XOR of all data nibbles, and out_last/out_flags move onto that beat.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready = FIFO not full)
//   in_data           result word
//   in_carry          carry status for in_data
//   in_overflow       overflow status for in_data
//   out_valid/out_ready downstream beat handshake (out_valid = FIFO not empty)
//   out_nibble        current beat
//   out_first         beat is the first of its word
//   out_last          beat is the last of its word
//   out_flags         {carry, overflow} on the last beat, 0 otherwise
module result_nibble_tx #(
  parameter int DATA_W = 8,
  parameter int NIB_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_carry,
  input  logic              in_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIB_W-1:0]  out_nibble,
  output logic              out_first,
  output logic              out_last,
  output logic [1:0]        out_flags
);

  localparam int BEATS = DATA_W / NIB_W;
`ifdef PARITY_NIBBLE_EN
  localparam int NBEATS = BEATS + 1;
`else
  localparam int NBEATS = BEATS;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(NBEATS - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              ovf;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            full, empty, push, pop, beat_xfer, last_beat;
  entry_t          head;
  logic [NIB_W-1:0] nib;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full      = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty     = (wr_q == rd_q);
  assign head      = mem_q[rd_q[AW-1:0]];

  // A full FIFO refuses pushes even when the head pops this cycle.
  assign push      = in_valid && !full;
  assign beat_xfer = !empty && out_ready;
  assign last_beat = (beat_q == LAST_B);
  assign pop       = beat_xfer && last_beat;

  // Beat selection from the head entry.
  always_comb begin
    nib = '0;
    for (int i = 0; i < BEATS; i++)
      if (int'(beat_q) == i) nib = head.data[i*NIB_W +: NIB_W];
`ifdef PARITY_NIBBLE_EN
    begin
      logic [NIB_W-1:0] par;
      par = '0;
      for (int i = 0; i < BEATS; i++) par = par ^ head.data[i*NIB_W +: NIB_W];
      if (int'(beat_q) == BEATS) nib = par;
    end
`endif
  end

  // Outputs come only from flops, so a stall cannot disturb them and they
  // clear the instant reset asserts.
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_nibble = empty ? '0 : nib;
  assign out_first  = !empty && (beat_q == '0);
  assign out_last   = !empty && last_beat;
  assign out_flags  = (!empty && last_beat) ? {head.carry, head.ovf} : 2'b00;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = {in_data, in_carry, in_overflow};
    wr_d   = wr_q + PW'(push);
    rd_d   = rd_q + PW'(pop);
    beat_d = beat_q;
    if (beat_xfer) beat_d = last_beat ? '0 : beat_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      beat_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      beat_q <= beat_d;
    end
  end

endmodule
